// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word fetches over a
// request/grant interface with in-order responses, buffers returned words
// in a small queue and hands one instruction + PC per cycle to decode.
// Optional feature macro: FETCH_BYPASS_EN (same-cycle response bypass to
// decode when the queue is empty).
module fetch_unit #(
    parameter int                      ADDRESS_SIZE = 32,
    parameter logic [ADDRESS_SIZE-1:0] BOOT_ADDRESS = 32'h1000,
    parameter int                      QUEUE_DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    imem_req,
    output logic [ADDRESS_SIZE-1:0] imem_addr,
    input  logic                    imem_gnt,
    input  logic                    imem_rvalid,
    input  logic [ADDRESS_SIZE-1:0] imem_rdata,
    input  logic                    redirect_valid,
    input  logic [ADDRESS_SIZE-1:0] redirect_pc,
    output logic                    dec_valid,
    input  logic                    dec_ready,
    output logic [ADDRESS_SIZE-1:0] dec_instruction,
    output logic [ADDRESS_SIZE-1:0] dec_pc
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH = (CW+1)'(QUEUE_DEPTH);

    logic [ADDRESS_SIZE-1:0] pc_reg, pc_next;
    logic [PW-1:0]           head_reg, head_next, tail_reg, tail_next;
    logic [CW-1:0]           count_reg, count_next;
    logic [CW-1:0]           inflight_reg, inflight_next;
    logic [CW-1:0]           drop_reg, drop_next;

    logic [ADDRESS_SIZE-1:0] q_instr_reg [QUEUE_DEPTH];
    logic [ADDRESS_SIZE-1:0] q_pc_reg    [QUEUE_DEPTH];

    logic                    grant, resp_keep, q_write, deq, queue_nonempty;
    logic [CW:0]             occupancy;
    logic [CW-1:0]           live_cnt;
    logic [ADDRESS_SIZE-1:0] live_ofs, resp_pc, redirect_target;
    logic [ADDRESS_SIZE-1:0] head_instr, head_pc;

    // Issue control, response PC reconstruction and queue write/read decisions
    always_comb begin
        occupancy       = {1'b0, count_reg} + {1'b0, inflight_reg};
        imem_req        = !reset && (occupancy < DEPTH);
        imem_addr       = pc_reg;
        grant           = imem_req && imem_gnt;
        resp_keep       = imem_rvalid && (drop_reg == '0);
        // Live (non-dropped) fetches are contiguous and end just below pc_reg,
        // so the oldest live one sits live_cnt words behind the PC.
        live_cnt        = inflight_reg - drop_reg;
        live_ofs        = {{(ADDRESS_SIZE-CW-2){1'b0}}, live_cnt, 2'b00};
        resp_pc         = pc_reg - live_ofs;
        redirect_target = redirect_pc & ~{{(ADDRESS_SIZE-2){1'b0}}, 2'b11};
        queue_nonempty  = (count_reg != '0);
        head_instr      = q_instr_reg[head_reg];
        head_pc         = q_pc_reg[head_reg];
        deq             = queue_nonempty && dec_ready;
`ifdef FETCH_BYPASS_EN
        if (queue_nonempty) begin
            dec_valid       = 1'b1;
            dec_instruction = head_instr;
            dec_pc          = head_pc;
            q_write         = resp_keep && !redirect_valid;
        end else begin
            dec_valid       = resp_keep;
            dec_instruction = resp_keep ? imem_rdata : '0;
            dec_pc          = resp_keep ? resp_pc : '0;
            // A bypassed word taken by decode never enters the queue
            q_write         = resp_keep && !dec_ready && !redirect_valid;
        end
`else
        dec_valid       = queue_nonempty;
        dec_instruction = queue_nonempty ? head_instr : '0;
        dec_pc          = queue_nonempty ? head_pc : '0;
        q_write         = resp_keep && !redirect_valid;
`endif
    end

    // Next-state for PC, pointers and counters; redirect overrides the queue
    always_comb begin
        inflight_next = inflight_reg + CW'(grant) - CW'(imem_rvalid);
        pc_next       = grant ? pc_reg + ADDRESS_SIZE'(4) : pc_reg;
        head_next     = head_reg + PW'(deq);
        tail_next     = tail_reg + PW'(q_write);
        count_next    = count_reg + CW'(q_write) - CW'(deq);
        drop_next     = drop_reg - CW'(imem_rvalid && !resp_keep);
        if (redirect_valid) begin
            pc_next    = redirect_target;
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
            // Every request still outstanding after this edge, including a
            // grant taken this cycle, belongs to the old stream.
            drop_next  = inflight_next;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg       <= BOOT_ADDRESS;
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            inflight_reg <= '0;
            drop_reg     <= '0;
        end else begin
            pc_reg       <= pc_next;
            head_reg     <= head_next;
            tail_reg     <= tail_next;
            count_reg    <= count_next;
            inflight_reg <= inflight_next;
            drop_reg     <= drop_next;
        end
    end

    // Queue storage: one write port at the tail, entries need no reset
    generate
        for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_entry
            // Capture the response word and its PC into this entry
            always_ff @(posedge clk) begin
                if (q_write && (tail_reg == PW'(gi))) begin
                    q_instr_reg[gi] <= imem_rdata;
                    q_pc_reg[gi]    <= resp_pc;
                end
            end
        end
    endgenerate

endmodule
